// File: rtl/rx_data_ctrl_if.sv
// Byte/handshake bundle between the UART receive path, the receive buffer
// controller and its consumer.
//   slave  : buffer side (takes load/read/clear, drives byte, ready, flags, count)
//   master : surrounding side (drives load/read/clear, observes the rest)
interface rx_data_ctrl_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 load_buffer;
  logic [DATA_BITS-1:0] packet_data;
  logic                 data_read;
  logic                 clear_errors;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic [CW-1:0]        fifo_count;

  modport slave (
    input  load_buffer,
    input  packet_data,
    input  data_read,
    input  clear_errors,
    output rx_data,
    output data_ready,
    output overrun_error,
    output fifo_count
  );

  modport master (
    output load_buffer,
    output packet_data,
    output data_read,
    output clear_errors,
    input  rx_data,
    input  data_ready,
    input  overrun_error,
    input  fifo_count
  );
endinterface

// File: rtl/rx_data_ctrl.sv
// Receive buffer: DEPTH-entry FIFO plus one output register, with
// ready/read handoff to the consumer and a sticky overrun flag.
//   clk, n_rst (async, active-low); bus : rx_data_ctrl_if.slave
module rx_data_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4
) (
  input logic          clk,
  input logic          n_rst,
  rx_data_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  state_t               state;
  logic [DATA_BITS-1:0] rx_q;
  logic                 rdy_q;
  logic                 ovr_q;

  logic has_data;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign has_data = (count != '0);
  assign full     = (count == CW'(DEPTH));
  // Output register refills whenever it is empty or being consumed.
  assign pop  = has_data && ((state == EMPTY) || bus.data_read);
  // A pop frees a slot this cycle, so a full FIFO can still accept.
  assign push = bus.load_buffer && (!full || pop);
  assign drop = bus.load_buffer && full && !pop;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.packet_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= EMPTY;
      rx_q  <= '0;
      rdy_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (has_data) begin
            rx_q  <= mem[rd_ptr];
            rdy_q <= 1'b1;
            state <= VALID;
          end
        end
        VALID: begin
          if (bus.data_read) begin
            if (has_data) begin
              rx_q <= mem[rd_ptr];
            end else begin
              rdy_q <= 1'b0;
              state <= EMPTY;
            end
          end
        end
        default: begin
          rdy_q <= 1'b0;
          state <= EMPTY;
        end
      endcase
    end
  end

  // Set beats clear when both happen in one cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      ovr_q <= 1'b0;
    else if (drop)
      ovr_q <= 1'b1;
    else if (bus.clear_errors)
      ovr_q <= 1'b0;
  end

  assign bus.rx_data       = rx_q;
  assign bus.data_ready    = rdy_q;
  assign bus.overrun_error = ovr_q;
  assign bus.fifo_count    = count;
endmodule

// File: tb/tb_rx_data_ctrl.sv
// Directed bench for rx_data_ctrl: reset, single byte, fill/overrun,
// full push+pop, back-to-back reads, wrap, error clear, async reset.
module tb_rx_data_ctrl;
  logic clk;
  logic n_rst;
  int   total;
  int   bad;

  rx_data_ctrl_if #(.DATA_BITS(8), .DEPTH(4)) bus ();

  rx_data_ctrl #(.DATA_BITS(8), .DEPTH(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.load_buffer = 1'b1;
    bus.packet_data = b;
    tick();
    bus.load_buffer = 1'b0;
  endtask

  task automatic read_byte();
    bus.data_read = 1'b1;
    tick();
    bus.data_read = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.load_buffer  = 1'b0;
    bus.packet_data  = '0;
    bus.data_read    = 1'b0;
    bus.clear_errors = 1'b0;
    #12;
    total++;
    if (bus.rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rx_data got %h want 00", bus.rx_data);
    end
    total++;
    if (bus.data_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got %b want 0", bus.data_ready);
    end
    total++;
    if (bus.overrun_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovr got %b want 0", bus.overrun_error);
    end
    total++;
    if (bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_count got %0d want 0", bus.fifo_count);
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push_byte(8'hA5);
    total++;
    if (bus.fifo_count !== 3'd1 || bus.data_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_push count=%0d rdy=%b want 1 0",
               bus.fifo_count, bus.data_ready);
    end
    tick();
    total++;
    if (bus.data_ready !== 1'b1 || bus.rx_data !== 8'hA5 ||
        bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL single_present rdy=%b rx=%h cnt=%0d want 1 a5 0",
               bus.data_ready, bus.rx_data, bus.fifo_count);
    end
    read_byte();
    total++;
    if (bus.data_ready !== 1'b0 || bus.rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_read rdy=%b rx=%h want 0 a5",
               bus.data_ready, bus.rx_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++)
      push_byte(8'(i));
    total++;
    if (bus.rx_data !== 8'h01 || bus.fifo_count !== 3'd4 ||
        bus.overrun_error !== 1'b0 || bus.data_ready !== 1'b1) begin
      bad++;
      $display("FAIL fill_full rx=%h cnt=%0d ovr=%b rdy=%b want 01 4 0 1",
               bus.rx_data, bus.fifo_count, bus.overrun_error,
               bus.data_ready);
    end
    push_byte(8'h06);
    total++;
    if (bus.overrun_error !== 1'b1 || bus.fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL fill_drop ovr=%b cnt=%0d want 1 4",
               bus.overrun_error, bus.fifo_count);
    end
    for (int i = 1; i <= 5; i++) begin
      total++;
      if (bus.data_ready !== 1'b1 || bus.rx_data !== 8'(i)) begin
        bad++;
        $display("FAIL fill_drain%0d rdy=%b rx=%h want 1 %h",
                 i, bus.data_ready, bus.rx_data, 8'(i));
      end
      read_byte();
    end
    total++;
    if (bus.data_ready !== 1'b0 || bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL fill_end rdy=%b cnt=%0d want 0 0",
               bus.data_ready, bus.fifo_count);
    end
    bus.clear_errors = 1'b1;
    tick();
    bus.clear_errors = 1'b0;
  endtask

  task automatic test_full_simul();
    logic [7:0] exp [5];
    exp[0] = 8'h12;
    exp[1] = 8'h13;
    exp[2] = 8'h14;
    exp[3] = 8'h15;
    exp[4] = 8'h77;
    for (int i = 0; i < 5; i++)
      push_byte(8'h11 + 8'(i));
    bus.data_read   = 1'b1;
    bus.load_buffer = 1'b1;
    bus.packet_data = 8'h77;
    tick();
    bus.data_read   = 1'b0;
    bus.load_buffer = 1'b0;
    total++;
    if (bus.overrun_error !== 1'b0 || bus.fifo_count !== 3'd4 ||
        bus.rx_data !== 8'h12) begin
      bad++;
      $display("FAIL simul_full ovr=%b cnt=%0d rx=%h want 0 4 12",
               bus.overrun_error, bus.fifo_count, bus.rx_data);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.data_ready !== 1'b1 || bus.rx_data !== exp[i]) begin
        bad++;
        $display("FAIL simul_drain%0d rdy=%b rx=%h want 1 %h",
                 i, bus.data_ready, bus.rx_data, exp[i]);
      end
      read_byte();
    end
    total++;
    if (bus.data_ready !== 1'b0) begin
      bad++;
      $display("FAIL simul_end rdy=%b want 0", bus.data_ready);
    end
  endtask

  task automatic test_back_to_back();
    push_byte(8'h21);
    push_byte(8'h22);
    push_byte(8'h23);
    total++;
    if (bus.rx_data !== 8'h21 || bus.data_ready !== 1'b1 ||
        bus.fifo_count !== 3'd2) begin
      bad++;
      $display("FAIL b2b_start rx=%h rdy=%b cnt=%0d want 21 1 2",
               bus.rx_data, bus.data_ready, bus.fifo_count);
    end
    bus.data_read = 1'b1;
    tick();
    total++;
    if (bus.rx_data !== 8'h22 || bus.data_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_1 rx=%h rdy=%b want 22 1",
               bus.rx_data, bus.data_ready);
    end
    tick();
    total++;
    if (bus.rx_data !== 8'h23 || bus.data_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_2 rx=%h rdy=%b want 23 1",
               bus.rx_data, bus.data_ready);
    end
    tick();
    total++;
    if (bus.data_ready !== 1'b0 || bus.rx_data !== 8'h23) begin
      bad++;
      $display("FAIL b2b_3 rx=%h rdy=%b want 23 0",
               bus.rx_data, bus.data_ready);
    end
    tick();
    bus.data_read = 1'b0;
    total++;
    if (bus.data_ready !== 1'b0 || bus.rx_data !== 8'h23 ||
        bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL b2b_empty_read rx=%h rdy=%b cnt=%0d want 23 0 0",
               bus.rx_data, bus.data_ready, bus.fifo_count);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    for (int i = 0; i < 11; i++) begin
      b = 8'h30 + 8'(i * 7);
      push_byte(b);
      tick();
      total++;
      if (bus.data_ready !== 1'b1 || bus.rx_data !== b) begin
        bad++;
        $display("FAIL wrap%0d rdy=%b rx=%h want 1 %h",
                 i, bus.data_ready, bus.rx_data, b);
      end
      read_byte();
    end
    total++;
    if (bus.data_ready !== 1'b0 || bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL wrap_end rdy=%b cnt=%0d want 0 0",
               bus.data_ready, bus.fifo_count);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 5; i++)
      push_byte(8'h41 + 8'(i));
    bus.clear_errors = 1'b1;
    push_byte(8'h46);
    bus.clear_errors = 1'b0;
    total++;
    if (bus.overrun_error !== 1'b1) begin
      bad++;
      $display("FAIL err_set_wins ovr=%b want 1", bus.overrun_error);
    end
    bus.clear_errors = 1'b1;
    tick();
    bus.clear_errors = 1'b0;
    total++;
    if (bus.overrun_error !== 1'b0) begin
      bad++;
      $display("FAIL err_clear ovr=%b want 0", bus.overrun_error);
    end
    for (int i = 0; i < 5; i++)
      read_byte();
    push_byte(8'h51);
    push_byte(8'h52);
    push_byte(8'h53);
    push_byte(8'h54);
    total++;
    if (bus.rx_data !== 8'h51 || bus.fifo_count !== 3'd3) begin
      bad++;
      $display("FAIL err_pre_rst rx=%h cnt=%0d want 51 3",
               bus.rx_data, bus.fifo_count);
    end
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if (bus.rx_data !== 8'h00 || bus.data_ready !== 1'b0 ||
        bus.overrun_error !== 1'b0 || bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL async_rst rx=%h rdy=%b ovr=%b cnt=%0d want 00 0 0 0",
               bus.rx_data, bus.data_ready, bus.overrun_error,
               bus.fifo_count);
    end
    tick();
    n_rst = 1'b1;
    tick();
    push_byte(8'h99);
    tick();
    total++;
    if (bus.rx_data !== 8'h99 || bus.data_ready !== 1'b1 ||
        bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL post_rst rx=%h rdy=%b cnt=%0d want 99 1 0",
               bus.rx_data, bus.data_ready, bus.fifo_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_back_to_back();
    test_wrap();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
